// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - banked single-port RAM with clear engine; optional parity via MEM_PARITY_EN
module banked_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int BANKS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              clr_i,
  input  logic              par_flip_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid_o,
  output logic              parity_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ROWS  = DEPTH / BANKS;
  localparam int BW    = $clog2(BANKS);
  localparam int RW    = ADDR_W - BW;
  localparam int BWX   = (BW > 0) ? BW : 1;
  localparam int RWX   = (RW > 0) ? RW : 1;
`ifdef MEM_PARITY_EN
  localparam int SW    = DATA_W + 1;
`else
  localparam int SW    = DATA_W;
`endif

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e            state_q;
  logic [RWX-1:0]    row_q;
  logic [RWX-1:0]    row_d;
  logic              ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic              parity_err_q;

  logic              accept;
  logic              rd_accept;
  logic [BWX-1:0]    bank_sel;
  logic [RWX-1:0]    row_sel;
  logic [SW-1:0]     wword;
  logic [SW-1:0]     rword;
  logic [SW-1:0]     bank_rdata [BANKS];
  logic              rd_perr;

  assign accept    = req_i && ready_q;
  assign rd_accept = accept && !we_i;
  assign row_sel   = RWX'(addr_i);
  assign bank_sel  = BWX'(addr_i >> RW);
  assign rword     = bank_rdata[bank_sel];
  assign row_d     = row_q + 1'b1;

`ifdef MEM_PARITY_EN
  // Extra stored bit holds even parity; par_flip deliberately corrupts it for testing
  assign wword   = {(^in_i) ^ par_flip_i, in_i};
  assign rd_perr = rword[DATA_W] ^ (^rword[DATA_W-1:0]);
`else
  logic unused_par_flip;
  assign unused_par_flip = par_flip_i;
  assign wword           = in_i;
  assign rd_perr         = 1'b0;
`endif

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [SW-1:0] mem [ROWS];
    logic          bank_we;

    assign bank_we = accept && we_i && (bank_sel == BWX'(g));

    // Clear engine zeroes the current row in every bank; otherwise accepted writes land here
    always_ff @(posedge clk_i) begin
      if (state_q == S_CLEAR) begin
        mem[row_q] <= '0;
      end else if (bank_we) begin
        mem[row_sel] <= wword;
      end
    end

    assign bank_rdata[g] = mem[row_sel];
  end

  // Control FSM: clear sweep, idle handshake, and registered read outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_CLEAR;
      row_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      out_valid_q  <= rd_accept;
      parity_err_q <= rd_accept && rd_perr;
      if (rd_accept) begin
        out_q <= rword[DATA_W-1:0];
      end
      case (state_q)
        S_CLEAR: begin
          if (clr_i) begin
            row_q <= '0;
          end else if (row_q == RWX'(ROWS - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            row_q <= row_d;
          end
        end
        S_IDLE: begin
          if (clr_i) begin
            state_q <= S_CLEAR;
            row_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: doc/banked_memory.md
# banked_memory

Parametrised single-port banked RAM; successor to the fixed 4096 x 8 memory. The top address bits select one of BANKS banks. Adds:
- a valid/ready request handshake;
- a registered read path with a data-valid strobe;
- a hardware clear engine that zeroes every word after reset or on command;
- an optional per-word parity check.

It is the general-purpose data store behind the CPU and DMA datapaths.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 12, address width; depth = 2^ADDR_W words
- BANKS, 4, bank count; power of two, 1 to 2^ADDR_W; each bank holds 2^ADDR_W / BANKS words

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request valid
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address; bank = top log2(BANKS) bits, row = remaining low bits
- in  in  DATA_W  write data
- clr  in  1  one-cycle pulse that restarts the clear engine
- par_flip  in  1  debug: invert stored parity on this write
- ready  out  1  block can accept a request
- busy  out  1  clear engine running
- out  out  DATA_W  read data
- out_valid  out  1  out holds fresh read data this cycle
- parity_err  out  1  parity mismatch on the current out_valid word

## Operation
- States:
  - CLEAR: the row counter runs from 0 to ROWS-1, where ROWS = 2^ADDR_W / BANKS. Every cycle, all banks write 0 (and parity 0) at the current row in parallel. After the row ROWS-1 write, the state moves to IDLE.
  - IDLE: ready = 1, and requests are accepted.
- Reset drives the state to CLEAR with the counter at 0. Clearing begins on the first clk edge after rst_n deasserts.
- Reset values:
  - out = 0, out_valid = 0, parity_err = 0
  - ready = 0, busy = 1
- ready = (state == IDLE) and busy = (state == CLEAR), both decoded from registered state.
- A request is accepted when req && ready at a rising edge. req while ready = 0 is dropped: no write, no out_valid. There is no backpressure on reads.
- Write: the addressed word is updated at the accepting edge. out and out_valid are unaffected by a write.
- Read: the addressed word is registered into out at the accepting edge, and out_valid = 1 for the following cycle. out keeps its value until the next accepted read.
- clr in IDLE: at the next edge the state moves to CLEAR with the counter at 0, and ready drops. A request presented in the same cycle as clr is still accepted and executes first. clr while in CLEAR restarts the counter at 0.
- rst_n asserted during CLEAR or IDLE: the state returns to CLEAR immediately. Memory contents are not reset directly, only by the subsequent clear.
- Address space is exactly 2^ADDR_W, so no address is out of range and there is no wrap logic.

## Timing
- Read latency is 1 cycle. With a request accepted at edge N, out and out_valid are valid after edge N, and data can be sampled at edge N+1.
- Back-to-back requests are accepted every cycle in IDLE, at throughput 1 per cycle.
- Read-after-write to the same address on consecutive cycles returns the newly written data.
- Clear duration is exactly ROWS cycles; ready rises after the edge that writes row ROWS-1. With default parameters this is 1024 cycles.
- out_valid and parity_err are registered and are never asserted during CLEAR, except for the out_valid cycle of a read accepted in the same cycle as clr.

## Configuration
- MEM_PARITY_EN defined:
  - Each word stores DATA_W+1 bits, with the extra bit holding even parity of the data.
  - A write with par_flip = 1 stores inverted parity.
  - On a read, parity_err = 1 in the out_valid cycle if the stored parity does not match.
- MEM_PARITY_EN undefined:
  - Storage is DATA_W bits wide, and par_flip is ignored.
  - parity_err is tied to 0.
  - All ports are still present.

## Test plan
- Reset then clear: release rst_n and wait for ready. Read 0x000 and 0xFFF -> out = 0x00, out_valid pulses, and ready rose exactly 1024 cycles after the first clk edge following rst_n release.
- Bank boundaries: write A1/A2/A3 to 0x000/0x200/0x3FF, B1-B3 to 0x400/0x600/0x7FF, C1-C3 to 0x800/0xA00/0xBFF, and D1-D3 to 0xC00/0xE00/0xFFF. Read all 12 back -> each value returns 1 cycle after its request.
- Back-to-back: write 0x5A to 0x123, then read 0x123 next cycle -> out = 0x5A with out_valid in the following cycle.
- Command clear: after the previous test, pulse clr together with a read of 0x7FF. That read still returns 0xB3, and ready is low for 1024 cycles. A req during that window is ignored. Afterwards, a read of 0x7FF -> 0x00.
- Reset mid-clear: assert rst_n low 300 cycles into a clear -> outputs return to reset values immediately, and the clear restarts for a full 1024 cycles.
- Parity (with MEM_PARITY_EN): write 0x3C to 0x010 with par_flip = 1 and 0x3C to 0x011 with par_flip = 0. Reading 0x010 -> parity_err = 1; reading 0x011 -> parity_err = 0. Without the macro, both reads give parity_err = 0.
